mem_access_unit: RTL

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit_pkg.sv | 13 +
 rtl/mem_access_unit.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/mem_access_unit_pkg.sv
// Shared types and constants for the MEM-stage access unit.
// Holds the FSM state encoding, default timeout and counter width.
package mem_access_unit_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } mau_state_e;

    localparam int TIMEOUT_CYCLES_DEFAULT = 16;
    localparam int CNT_W                  = 8;

endpackage : mem_access_unit_pkg

// File: rtl/mem_access_unit.sv
// MEM stage with a handshake to a variable-latency backing memory.
// Stalls the front of the pipeline while a request is in flight and aborts on timeout.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        RegWrite_i,
    input  logic        MemWrite_i,
    input  logic        MemRead_i,
    input  logic        MemtoReg_i,
    input  logic [31:0] ALU_Result_i,
    input  logic [31:0] muxBresult_i,
    input  logic [4:0]  RDaddr_i,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i,
    output logic        stall_o,
    output logic        RegWrite_o,
    output logic        MemtoReg_o,
    output logic [31:0] ReadData_o,
    output logic [31:0] ALU_Result_o,
    output logic [4:0]  RDaddr_o,
    output logic        err_o
);

    mau_state_e        state_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic              mem_req_reg;
    logic              mem_we_reg;
    logic [31:0]       mem_addr_reg;
    logic [31:0]       mem_wdata_reg;
    logic              err_reg;
    logic              reg_write_reg;
    logic              mem_to_reg_reg;
    logic [31:0]       read_data_reg;
    logic [31:0]       alu_result_reg;
    logic [4:0]        rd_addr_reg;

    logic memop;
    logic aligned;
    logic timeout_hit;

    assign memop       = MemRead_i | MemWrite_i;
    assign aligned     = (ALU_Result_i[1:0] == 2'b00);
    assign timeout_hit = (cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));

    // Stall drops in the final ACCESS cycle (ack or timeout) so the
    // pipeline advances on the same edge that retires the access.
    always_comb begin
        stall_o = 1'b0;
        if (!rst_i) begin
            case (state_reg)
                IDLE:    stall_o = memop & aligned;
                ACCESS:  stall_o = !mem_ack_i && !timeout_hit;
                default: stall_o = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg      <= IDLE;
            cnt_reg        <= '0;
            mem_req_reg    <= 1'b0;
            mem_we_reg     <= 1'b0;
            mem_addr_reg   <= '0;
            mem_wdata_reg  <= '0;
            err_reg        <= 1'b0;
            reg_write_reg  <= 1'b0;
            mem_to_reg_reg <= 1'b0;
            read_data_reg  <= '0;
            alu_result_reg <= '0;
            rd_addr_reg    <= '0;
        end else begin
            err_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (memop) begin
                        // Any memop leaves a bubble in MEM/WB; result arrives on ack.
                        reg_write_reg  <= 1'b0;
                        mem_to_reg_reg <= 1'b0;
                        rd_addr_reg    <= '0;
                        if (aligned) begin
                            state_reg     <= ACCESS;
                            cnt_reg       <= '0;
                            mem_req_reg   <= 1'b1;
                            mem_we_reg    <= MemWrite_i;
                            mem_addr_reg  <= ALU_Result_i;
                            mem_wdata_reg <= muxBresult_i;
                        end else begin
                            err_reg <= 1'b1;
                        end
                    end else begin
                        reg_write_reg  <= RegWrite_i;
                        mem_to_reg_reg <= MemtoReg_i;
                        alu_result_reg <= ALU_Result_i;
                        rd_addr_reg    <= RDaddr_i;
                    end
                end
                ACCESS: begin
                    if (mem_ack_i) begin
                        state_reg      <= IDLE;
                        mem_req_reg    <= 1'b0;
                        mem_we_reg     <= 1'b0;
                        reg_write_reg  <= RegWrite_i;
                        mem_to_reg_reg <= MemtoReg_i;
                        alu_result_reg <= ALU_Result_i;
                        rd_addr_reg    <= RDaddr_i;
                        if (!mem_we_reg) begin
                            read_data_reg <= mem_rdata_i;
                        end
                    end else if (timeout_hit) begin
                        state_reg      <= IDLE;
                        mem_req_reg    <= 1'b0;
                        mem_we_reg     <= 1'b0;
                        err_reg        <= 1'b1;
                        reg_write_reg  <= 1'b0;
                        mem_to_reg_reg <= 1'b0;
                        rd_addr_reg    <= '0;
                    end else begin
                        cnt_reg        <= cnt_reg + CNT_W'(1);
                        reg_write_reg  <= 1'b0;
                        mem_to_reg_reg <= 1'b0;
                        rd_addr_reg    <= '0;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign mem_req_o    = mem_req_reg;
    assign mem_we_o     = mem_we_reg;
    assign mem_addr_o   = mem_addr_reg;
    assign mem_wdata_o  = mem_wdata_reg;
    assign err_o        = err_reg;
    assign RegWrite_o   = reg_write_reg;
    assign MemtoReg_o   = mem_to_reg_reg;
    assign ReadData_o   = read_data_reg;
    assign ALU_Result_o = alu_result_reg;
    assign RDaddr_o     = rd_addr_reg;

endmodule : mem_access_unit
